tlul_host_arb: RTL and testbench
================================

// Module: tlul_host_arb
// PURPOSE
//  Round-robin arbiter sharing one TL-UL device port (typically a tlul_adapter_reg
//  front-end) among NumHosts TL-UL hosts. One transaction outstanding at a time.
//  Locks grant from A-channel accept to D-channel completion. Routes the response
//  back to the granted host. Sits between the crossbar host ports and a register block.
// PARAMETERS
//  NumHosts       2    number of requesting hosts, 2..8
//  TimeoutCycles  255  D-channel wait limit in cycles (used only with the macro), >=1
//  (localparam) CntW = $clog2(TimeoutCycles+1); HW = $clog2(NumHosts)
// PORTS
//  clk_i        in   1                  clock
//  rst_ni       in   1                  asynchronous active-low reset
//  tl_h_i       in   NumHosts x tl_h2d  host requests
//  tl_h_o       out  NumHosts x tl_d2h  host responses
//  tl_d_o       out  tl_h2d             request to shared device
//  tl_d_i       in   tl_d2h             response from shared device
//  gnt_o        out  NumHosts           one-hot current owner, 0 when IDLE
//  busy_o       out  1                  high in any state other than IDLE
//  timeout_o    out  1                  1-cycle pulse on timeout (0 without macro)
// BEHAVIOUR
//  Reset: state IDLE, rr_q=NumHosts-1, gnt_o=0, busy_o=0, timeout_o=0; all tl_h_o
//   a_ready/d_valid=0; tl_d_o a_valid=0, d_ready=0; latched opcode/size/source=0.
//  FSM states: IDLE, ADDR, RESP, ERSP, DRAIN.
//  IDLE: if any tl_h_i[k].a_valid, the winner is the first requester searching upward
//   from rr_q+1 (mod NumHosts). Register gnt_q=winner, rr_q=winner, go to ADDR.
//   With no requests, stay in IDLE. Device a_valid appears 1 cycle after host a_valid.
//  ADDR: tl_d_o A-fields = tl_h_i[gnt_q] A-fields; a_user is passed unmodified so
//   downstream integrity checks remain valid. tl_h_o[gnt_q].a_ready = tl_d_i.a_ready.
//   On device A handshake: latch a_opcode, a_size, a_source; clear timer; go to RESP.
//   Non-granted hosts see a_ready=0 in all states.
//  RESP: tl_h_o[gnt_q] D-fields = tl_d_i D-fields; tl_d_o.d_ready = tl_h_i[gnt_q].d_ready.
//   On D handshake, go to IDLE (gnt_o=0 next cycle). Timer increments each cycle.
//   Back-to-back throughput: 1 transaction per 3 cycles minimum (IDLE, ADDR, RESP).
//  A-channel and D-channel handshakes never complete in the same state.
//   A device d_valid seen in ADDR is ignored (d_ready=0).
//  Reset mid-transaction: all state drops asynchronously. The in-flight transaction
//   is abandoned, with no response to the host.
//  Host withdrawing a_valid in ADDR is a protocol violation. Covered by assertion
//   only; the arbiter keeps the grant.
// CONFIGURATION
//  Macro TLUL_HOST_ARB_TIMEOUT_EN.
//  Defined: in RESP, when the timer reaches TimeoutCycles without device d_valid,
//   pulse timeout_o and go to ERSP.
//   ERSP: tl_h_o[gnt_q] d_valid=1, d_error=1, d_data='1, d_opcode=AccessAckData
//    for Get (else AccessAck), d_size/d_source=latched values, d_user='0.
//    On host d_ready, go to DRAIN.
//   DRAIN: tl_d_o.d_ready=1; the device response is consumed and discarded.
//    Then go to IDLE. busy_o stays high throughout.
//  Not defined: no timer; ERSP/DRAIN unreachable; timeout_o tied 0; RESP waits forever.
// TESTING
//  T1 host0 and host1 raise Get in the same cycle after reset (rr_q=1) -> host0 served
//     first, then host1; device sees 2 requests; sources are returned correctly.
//  T2 host1 issues 4 back-to-back Puts, host0 idles -> 4 grants to host1, each 3 cycles
//     apart; then host0 Get -> served next.
//  T3 device holds a_ready=0 for 5 cycles in ADDR -> tl_d_o A-fields stable;
//     host a_ready rises in the same cycle as device a_ready.
//  T4 host0 holds d_ready=0 for 4 cycles with device d_data=0xA5A5_0001 -> data held
//     stable; grant is not released until the handshake.
//  T5 (macro on, TimeoutCycles=8) device never responds -> timeout_o pulse 8 cycles
//     after the A handshake; host gets d_error=1, d_data=0xFFFF_FFFF; a late device
//     response is drained; no host sees it.
//  T6 assert rst_ni low while in RESP -> all outputs return to reset values
//     asynchronously; after reset the next request is arbitrated from host0.

Source files
------------

// File: rtl/tlul_host_arb.sv
// Round-robin arbiter sharing one TL-UL device port among NumHosts hosts, one transaction in flight.
// Optional D-channel timeout with error response is enabled by defining TLUL_HOST_ARB_TIMEOUT_EN.

package tlul_host_arb_pkg;

    localparam logic [2:0] OpPutFull       = 3'h0;
    localparam logic [2:0] OpPutPartial    = 3'h1;
    localparam logic [2:0] OpGet           = 3'h4;
    localparam logic [2:0] OpAccessAck     = 3'h0;
    localparam logic [2:0] OpAccessAckData = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_host_arb
    import tlul_host_arb_pkg::*;
#(
    parameter int unsigned NumHosts      = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  tl_h2d_t             tl_h_i [NumHosts],
    output tl_d2h_t             tl_h_o [NumHosts],
    output tl_h2d_t             tl_d_o,
    input  tl_d2h_t             tl_d_i,
    output logic [NumHosts-1:0] gnt_o,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int unsigned HW = $clog2(NumHosts);

    typedef enum logic [2:0] {StIdle, StAddr, StResp, StErsp, StDrain} state_e;

    state_e          r_state, w_state_nxt;
    logic [HW-1:0]   r_gnt, r_rr, w_winner, w_sel;
    logic            w_found, w_a_hs;
    int unsigned     w_idx;

    // First requester searching upward from the host after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_sel    = '0;
        for (int unsigned i = 1; i <= NumHosts; i++) begin
            w_idx = (32'(r_rr) + i) % NumHosts;
            w_sel = HW'(w_idx);
            if (!w_found && tl_h_i[w_sel].a_valid) begin
                w_found  = 1'b1;
                w_winner = w_sel;
            end
        end
    end

    assign w_a_hs = (r_state == StAddr) && tl_h_i[r_gnt].a_valid && tl_d_i.a_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_gnt   <= '0;
            r_rr    <= HW'(NumHosts - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && w_found) begin
                r_gnt <= w_winner;
                r_rr  <= w_winner;
            end
        end
    end

`ifdef TLUL_HOST_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] r_timer;
    logic [2:0]      r_opcode;
    logic [1:0]      r_size;
    logic [7:0]      r_source;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timer  <= '0;
            r_opcode <= '0;
            r_size   <= '0;
            r_source <= '0;
        end else if (w_a_hs) begin
            r_timer  <= '0;
            r_opcode <= tl_h_i[r_gnt].a_opcode;
            r_size   <= tl_h_i[r_gnt].a_size;
            r_source <= tl_h_i[r_gnt].a_source;
        end else if (r_state == StResp) begin
            r_timer <= r_timer + CntW'(1);
        end
    end

    assign timeout_o = (r_state == StResp) && !tl_d_i.d_valid
                       && (r_timer == CntW'(TimeoutCycles - 1));
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        tl_d_o      = '0;
        for (int unsigned k = 0; k < NumHosts; k++) begin
            tl_h_o[k] = '0;
        end
        unique case (r_state)
            StIdle: begin
                if (w_found) w_state_nxt = StAddr;
            end
            StAddr: begin
                // a_user passes through untouched so integrity checks downstream still hold.
                tl_d_o                 = tl_h_i[r_gnt];
                tl_d_o.d_ready         = 1'b0;
                tl_h_o[r_gnt].a_ready  = tl_d_i.a_ready;
                if (w_a_hs) w_state_nxt = StResp;
            end
            StResp: begin
                tl_h_o[r_gnt]         = tl_d_i;
                tl_h_o[r_gnt].a_ready = 1'b0;
                tl_d_o.d_ready        = tl_h_i[r_gnt].d_ready;
                if (tl_d_i.d_valid && tl_h_i[r_gnt].d_ready) begin
                    w_state_nxt = StIdle;
                end else if (timeout_o) begin
                    w_state_nxt = StErsp;
                end
            end
`ifdef TLUL_HOST_ARB_TIMEOUT_EN
            StErsp: begin
                tl_h_o[r_gnt].d_valid  = 1'b1;
                tl_h_o[r_gnt].d_error  = 1'b1;
                tl_h_o[r_gnt].d_data   = '1;
                tl_h_o[r_gnt].d_opcode = (r_opcode == OpGet) ? OpAccessAckData : OpAccessAck;
                tl_h_o[r_gnt].d_size   = r_size;
                tl_h_o[r_gnt].d_source = r_source;
                if (tl_h_i[r_gnt].d_ready) w_state_nxt = StDrain;
            end
            StDrain: begin
                // Late device response is swallowed; the host already got its error.
                tl_d_o.d_ready = 1'b1;
                if (tl_d_i.d_valid) w_state_nxt = StIdle;
            end
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        gnt_o = '0;
        if (r_state != StIdle) gnt_o[r_gnt] = 1'b1;
    end

    assign busy_o = (r_state != StIdle);

    params_a: assert property (@(posedge clk_i)
        NumHosts >= 2 && NumHosts <= 8 && TimeoutCycles >= 1);

    // Withdrawing a_valid before acceptance is a host protocol violation; the grant is kept.
    a_valid_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == StAddr) |-> tl_h_i[r_gnt].a_valid);

endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed bench for tlul_host_arb: a responding device model, host stimulus and a per-host
// response scoreboard; the timeout scenario runs only when TLUL_HOST_ARB_TIMEOUT_EN is defined.
module tb_tlul_host_arb;
    import tlul_host_arb_pkg::*;

    localparam int NH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    tl_h2d_t       h_i [NH];
    tl_d2h_t       h_o [NH];
    tl_h2d_t       d_o;
    tl_d2h_t       d_i;
    logic [NH-1:0] gnt;
    logic          busy, tmo;

    int   checks = 0;
    int   failures = 0;
    int   dev_cnt = 0;
    logic dev_resp_en = 1'b1;
    logic [7:0] dev_last_src = '0;

    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sbq0 [$];
    exp_t sbq1 [$];

    always #5 clk = ~clk;

    tlul_host_arb #(.NumHosts(NH), .TimeoutCycles(8)) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .tl_h_i    (h_i),
        .tl_h_o    (h_o),
        .tl_d_o    (d_o),
        .tl_d_i    (d_i),
        .gnt_o     (gnt),
        .busy_o    (busy),
        .timeout_o (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k, input logic [2:0] op, input logic [7:0] src,
                            input logic [31:0] data, input logic err);
        exp_t e;
        e = '{op: op, src: src, data: data, err: err};
        if (k == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endtask

    task automatic send(input int k, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [7:0] src, input bit push);
        h_i[k].a_opcode  = op;
        h_i[k].a_param   = 3'h0;
        h_i[k].a_size    = 2'd2;
        h_i[k].a_source  = src;
        h_i[k].a_address = addr;
        h_i[k].a_mask    = 4'hF;
        h_i[k].a_data    = data;
        h_i[k].a_user    = {8'hC0, src};
        h_i[k].a_valid   = 1'b1;
        if (push) push_exp(k, (op == OpGet) ? OpAccessAckData : OpAccessAck, src,
                           (op == OpGet) ? (addr ^ 32'hA5A5_0000) : 32'h0, 1'b0);
    endtask

    // Wait for host k's A handshake; n = negedges observed up to and including a_ready.
    task automatic wait_accept(input int k, output int n);
        bit   ok = 1'b0;
        logic other = 1'b0;
        n = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            n++;
            for (int j = 0; j < NH; j++) if (j != k && h_o[j].a_ready) other = 1'b1;
            if (h_o[k].a_ready) begin
                ok = 1'b1;
                chk("gnt_at_accept", 32'(gnt), 32'(1) << k);
            end
        end
        chk("accept_seen", 32'(ok), 32'd1);
        chk("a_ready_exclusive", 32'(other), 32'd0);
        if (ok) begin
            step();
            h_i[k].a_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (!busy && sbq0.size() == 0 && sbq1.size() == 0) ok = 1'b1;
        end
        chk("idle_reached", 32'(ok), 32'd1);
        step();
    endtask

    task automatic check_rsp(input int k);
        exp_t e;
        int   sz;
        sz = (k == 0) ? sbq0.size() : sbq1.size();
        if (sz == 0) begin
            chk("rsp_expected", 32'(sz), 32'd1);
        end else begin
            if (k == 0) e = sbq0.pop_front();
            else        e = sbq1.pop_front();
            chk("rsp_opcode", 32'(h_o[k].d_opcode), 32'(e.op));
            chk("rsp_source", 32'(h_o[k].d_source), 32'(e.src));
            chk("rsp_data",   h_o[k].d_data,        e.data);
            chk("rsp_error",  32'(h_o[k].d_error),  32'(e.err));
        end
    endtask

    // Response monitor: every accepted D beat on a host port must match its scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NH; k++) begin
                if (h_o[k].d_valid && h_i[k].d_ready) check_rsp(k);
            end
        end
    end

    // Device model: accepts when a_ready, answers the cycle after the A handshake.
    initial begin
        logic    a_hs, d_hs;
        tl_h2d_t req;
        forever begin
            @(negedge clk);
            a_hs = d_o.a_valid && d_i.a_ready;
            d_hs = d_i.d_valid && d_o.d_ready;
            req  = d_o;
            step();
            if (d_hs) d_i.d_valid = 1'b0;
            if (a_hs) begin
                dev_cnt++;
                dev_last_src = req.a_source;
                if (dev_resp_en) begin
                    d_i.d_valid  = 1'b1;
                    d_i.d_opcode = (req.a_opcode == OpGet) ? OpAccessAckData : OpAccessAck;
                    d_i.d_source = req.a_source;
                    d_i.d_size   = req.a_size;
                    d_i.d_data   = (req.a_opcode == OpGet) ? (req.a_address ^ 32'hA5A5_0000)
                                                           : 32'h0;
                    d_i.d_error  = 1'b0;
                end
            end
        end
    end

    initial begin
        int  n;
        time t, t_prev;
        bit  seen;
        for (int k = 0; k < NH; k++) begin
            h_i[k] = '0;
            h_i[k].d_ready = 1'b1;
        end
        d_i = '0;
        d_i.a_ready = 1'b1;
        t_prev = 0;

        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        chk("rst_dev_a_valid", 32'(d_o.a_valid), 32'd0);
        chk("rst_dev_d_ready", 32'(d_o.d_ready), 32'd0);
        for (int k = 0; k < NH; k++) begin
            chk("rst_host_a_ready", 32'(h_o[k].a_ready), 32'd0);
            chk("rst_host_d_valid", 32'(h_o[k].d_valid), 32'd0);
        end
        step();
        rst_n = 1'b1;
        step();

        // T1: simultaneous Gets after reset, host0 wins first.
        send(0, OpGet, 32'h10, 32'h0, 8'd3, 1'b1);
        send(1, OpGet, 32'h20, 32'h0, 8'd7, 1'b1);
        wait_accept(0, n);
        wait_accept(1, n);
        wait_idle();
        chk("t1_dev_cnt", 32'(dev_cnt), 32'd2);
        chk("t1_dev_last_src", 32'(dev_last_src), 32'd7);

        // T2: host1 back-to-back Puts, one grant every 3 cycles, then host0 Get.
        for (int i = 0; i < 4; i++) begin
            send(1, OpPutFull, 32'h40 + 32'(4 * i), 32'h1000 + 32'(i), 8'h10 + 8'(i), 1'b1);
            wait_accept(1, n);
            t = $time;
            if (i > 0) chk("t2_spacing", 32'(t - t_prev), 32'd30);
            t_prev = t;
        end
        send(0, OpGet, 32'h80, 32'h0, 8'd1, 1'b1);
        wait_accept(0, n);
        wait_idle();
        chk("t2_dev_cnt", 32'(dev_cnt), 32'd7);

        // T3: device stalls a_ready for 5 cycles in ADDR.
        d_i.a_ready = 1'b0;
        send(0, OpPutFull, 32'h100, 32'hDEAD_BEEF, 8'd2, 1'b1);
        @(negedge clk);
        chk("t3_dev_a_valid_latency", 32'(d_o.a_valid), 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("t3_a_valid", 32'(d_o.a_valid), 32'd1);
            chk("t3_a_addr", d_o.a_address, 32'h100);
            chk("t3_a_data", d_o.a_data, 32'hDEAD_BEEF);
            chk("t3_a_user", 32'(d_o.a_user), 32'hC002);
            chk("t3_host_a_ready", 32'(h_o[0].a_ready), 32'd0);
        end
        step();
        d_i.a_ready = 1'b1;
        wait_accept(0, n);
        chk("t3_a_ready_same_cycle", 32'(n), 32'd1);
        wait_idle();

        // T4: host0 back-pressures the response for 4 cycles.
        h_i[0].d_ready = 1'b0;
        send(0, OpGet, 32'h1, 32'h0, 8'd4, 1'b1);
        wait_accept(0, n);
        repeat (4) begin
            @(negedge clk);
            chk("t4_d_valid", 32'(h_o[0].d_valid), 32'd1);
            chk("t4_d_data", h_o[0].d_data, 32'hA5A5_0001);
            chk("t4_gnt_held", 32'(gnt), 32'd1);
        end
        step();
        h_i[0].d_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_gnt_released", 32'(gnt), 32'd0);
        chk("t4_busy_released", 32'(busy), 32'd0);
        wait_idle();

`ifdef TLUL_HOST_ARB_TIMEOUT_EN
        // T5: device silent; error response after 8 cycles, late response drained.
        dev_resp_en = 1'b0;
        send(0, OpGet, 32'h50, 32'h0, 8'd5, 1'b0);
        push_exp(0, OpAccessAckData, 8'd5, 32'hFFFF_FFFF, 1'b1);
        wait_accept(0, n);
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            n++;
            if (tmo) seen = 1'b1;
        end
        chk("t5_timeout_seen", 32'(seen), 32'd1);
        chk("t5_timeout_delay", 32'(n), 32'd8);
        @(negedge clk);
        chk("t5_timeout_pulse", 32'(tmo), 32'd0);
        step();
        d_i.d_valid  = 1'b1;
        d_i.d_data   = 32'h1234_5678;
        d_i.d_source = 8'd5;
        d_i.d_opcode = OpAccessAckData;
        @(negedge clk);
        chk("t5_drain_d_ready", 32'(d_o.d_ready), 32'd1);
        chk("t5_drain_host0_quiet", 32'(h_o[0].d_valid), 32'd0);
        chk("t5_drain_host1_quiet", 32'(h_o[1].d_valid), 32'd0);
        chk("t5_drain_busy", 32'(busy), 32'd1);
        step();
        d_i.d_valid = 1'b0;
        dev_resp_en = 1'b1;
        @(negedge clk);
        chk("t5_back_to_idle", 32'(busy), 32'd0);
        step();
`endif

        // T6: reset while in RESP; afterwards host0 must win again.
        dev_resp_en = 1'b0;
        send(0, OpGet, 32'h30, 32'h0, 8'd9, 1'b0);
        wait_accept(0, n);
        @(negedge clk);
        @(negedge clk);
        chk("t6_busy_in_resp", 32'(busy), 32'd1);
        chk("t6_d_ready_in_resp", 32'(d_o.d_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_dev_d_ready", 32'(d_o.d_ready), 32'd0);
        chk("t6_rst_dev_a_valid", 32'(d_o.a_valid), 32'd0);
        chk("t6_rst_host_d_valid", 32'(h_o[0].d_valid), 32'd0);
        chk("t6_rst_timeout", 32'(tmo), 32'd0);
        step();
        step();
        dev_resp_en = 1'b1;
        d_i.d_valid = 1'b0;
        rst_n = 1'b1;
        step();
        send(0, OpGet, 32'h60, 32'h0, 8'd11, 1'b1);
        send(1, OpGet, 32'h70, 32'h0, 8'd12, 1'b1);
        wait_accept(0, n);
        wait_accept(1, n);
        wait_idle();

        chk("sb_empty", 32'(sbq0.size() + sbq1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
